// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed little-endian program image into
// the instruction memory write port while holding the core in reset.
// Stream format: 16-bit word count (LSB first), then 32-bit words (LSB first).
module imem_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  writeEnable,
   output logic [ADDR_WIDTH-1:0] writeAddress,
   output logic [DATA_WIDTH-1:0] writeData,
   output logic                  core_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN0   = 3'd1,
      S_LEN1   = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   // Memory depth widened past 16 bits so a count of exactly 2^16-1 and a
   // depth of 2^ADDR_WIDTH compare without overflow.
   localparam logic [16:0] MEM_DEPTH = 17'(2 ** ADDR_WIDTH);

   state_t                  state_q;
   logic [7:0]              cnt_lo_q;
   logic [15:0]             count_q;
   logic [15:0]             index_q;
   logic [1:0]              byte_q;
   logic [23:0]             asm_q;
   logic                    in_ready_q;
   logic                    write_en_q;
   logic [ADDR_WIDTH-1:0]   write_addr_q;
   logic [DATA_WIDTH-1:0]   write_data_q;
   logic                    core_hold_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    error_q;

   logic                    accept_d;
   logic [15:0]             count_d;
   logic [15:0]             index_d;
   logic                    in_range_d;

   // Transfer qualifier and next values used by several states.
   assign accept_d   = in_valid && in_ready_q;
   assign count_d    = {in_data, cnt_lo_q};
   assign index_d    = index_q + 16'd1;
   assign in_range_d = ({1'b0, index_q} < MEM_DEPTH);

   assign in_ready     = in_ready_q;
   assign writeEnable  = write_en_q;
   assign writeAddress = write_addr_q;
   assign writeData    = write_data_q;
   assign core_hold    = core_hold_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;

   // Loader FSM; every output is a register updated alongside the state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_lo_q     <= 8'd0;
         count_q      <= 16'd0;
         index_q      <= 16'd0;
         byte_q       <= 2'd0;
         asm_q        <= 24'd0;
         in_ready_q   <= 1'b0;
         write_en_q   <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
         core_hold_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  done_q      <= 1'b0;
                  error_q     <= 1'b0;
                  index_q     <= 16'd0;
                  byte_q      <= 2'd0;
                  asm_q       <= 24'd0;
                  in_ready_q  <= 1'b1;
                  core_hold_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_LEN0;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_LEN0: begin
               if (accept_d) begin
                  cnt_lo_q <= in_data;
                  state_q  <= S_LEN1;
               end else begin
                  state_q <= S_LEN0;
               end
            end
            S_LEN1: begin
               if (accept_d) begin
                  count_q <= count_d;
                  // Oversized images still stream through; the excess is dropped.
                  if ({1'b0, count_d} > MEM_DEPTH) begin
                     error_q <= 1'b1;
                  end else begin
                     error_q <= error_q;
                  end
                  if (count_d == 16'd0) begin
                     in_ready_q  <= 1'b0;
                     core_hold_q <= 1'b0;
                     state_q     <= S_FINISH;
                  end else begin
                     state_q <= S_DATA;
                  end
               end else begin
                  state_q <= S_LEN1;
               end
            end
            S_DATA: begin
               if (accept_d) begin
                  if (byte_q == 2'd3) begin
                     // Fourth byte completes the word; strobe it out next cycle.
                     byte_q     <= 2'd0;
                     in_ready_q <= 1'b0;
                     if (in_range_d) begin
                        write_en_q   <= 1'b1;
                        write_addr_q <= index_q[ADDR_WIDTH-1:0];
                        write_data_q <= DATA_WIDTH'({in_data, asm_q});
                     end else begin
                        write_en_q <= 1'b0;
                     end
                     state_q <= S_WRITE;
                  end else begin
                     case (byte_q)
                        2'd0:    asm_q[7:0]   <= in_data;
                        2'd1:    asm_q[15:8]  <= in_data;
                        2'd2:    asm_q[23:16] <= in_data;
                        default: asm_q        <= asm_q;
                     endcase
                     byte_q  <= byte_q + 2'd1;
                     state_q <= S_DATA;
                  end
               end else begin
                  state_q <= S_DATA;
               end
            end
            S_WRITE: begin
               write_en_q <= 1'b0;
               index_q    <= index_d;
               if (index_d == count_q) begin
                  core_hold_q <= 1'b0;
                  state_q     <= S_FINISH;
               end else begin
                  in_ready_q <= 1'b1;
                  state_q    <= S_DATA;
               end
            end
            S_FINISH: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               in_ready_q  <= 1'b0;
               write_en_q  <= 1'b0;
               core_hold_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
